pipe_hazard_ctrl: RTL and testbench

//  Sequences the 5-stage pipeline registers (PC, IF/ID, ID/EXE, EXE/MEM, MEM/WB).

---
 rtl/pipe_hazard_ctrl.sv | 142 ++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: load/flush enables for PC, IF/ID, ID/EXE, EXE/MEM and MEM/WB.
// Zero-cycle (Mealy) outputs; mem_busy freezes every stage, so memory wait has priority over branch and RAW stall.
// Optional FORWARDING_EN macro narrows the RAW hazard to load-use only.
module pipe_hazard_ctrl #(
  parameter int LOAD_BUBBLES = 1,
  parameter int MEM_TIMEOUT  = 255,
  parameter int CNT_W        = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [3:0]       src1,
  input  logic [3:0]       src2,
  input  logic             two_src,
  input  logic             id_valid,
  input  logic [3:0]       exe_dest,
  input  logic             exe_wb_en,
  input  logic             exe_mem_r_en,
  input  logic [3:0]       mem_dest,
  input  logic             mem_wb_en,
  input  logic             branch_taken,
  input  logic             mem_busy,
  output logic             pc_ld,
  output logic             if_id_ld,
  output logic             if_id_flush,
  output logic             id_exe_ld,
  output logic             id_exe_flush,
  output logic             exe_mem_ld,
  output logic             mem_wb_ld,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {RUN, STALL, FREEZE} state_t;

  localparam logic [2:0]  BUB_INIT = 3'(LOAD_BUBBLES - 1);
  localparam logic [15:0] BUSY_MAX = 16'(MEM_TIMEOUT);

  state_t           state_q, state_d;
  logic [2:0]       bub_q, bub_d;
  logic [15:0]      busy_q, busy_d;
  logic             err_q, err_d;
  logic             resume_stall_q, resume_stall_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic raw_e, raw_m, hazard, in_stall, stalling;
  logic pc_ld_c, if_id_ld_c, if_id_flush_c, id_exe_ld_c, id_exe_flush_c, exe_mem_ld_c, mem_wb_ld_c;

  always_comb begin
    raw_e = id_valid & exe_wb_en & ((src1 == exe_dest) | (two_src & (src2 == exe_dest)));
    raw_m = id_valid & mem_wb_en & ((src1 == mem_dest) | (two_src & (src2 == mem_dest)));
`ifdef FORWARDING_EN
    hazard = raw_e & exe_mem_r_en;
`else
    hazard = raw_e | raw_m;
`endif
    // A freeze that interrupted a stall resumes that stall, keeping its remaining bubbles.
    in_stall = (state_q == STALL) | ((state_q == FREEZE) & resume_stall_q);
    stalling = in_stall ? ((bub_q != 3'd0) | hazard) : hazard;
  end

  always_comb begin
    state_d        = state_q;
    bub_d          = bub_q;
    busy_d         = busy_q;
    err_d          = err_q;
    resume_stall_d = resume_stall_q;
    pc_ld_c        = 1'b0;
    if_id_ld_c     = 1'b0;
    if_id_flush_c  = 1'b0;
    id_exe_ld_c    = 1'b0;
    id_exe_flush_c = 1'b0;
    exe_mem_ld_c   = 1'b0;
    mem_wb_ld_c    = 1'b0;

    if (mem_busy) begin
      state_d = FREEZE;
      if (state_q != FREEZE) resume_stall_d = (state_q == STALL);
      busy_d = (busy_q == BUSY_MAX) ? busy_q : busy_q + 16'd1;
      if (busy_d == BUSY_MAX) err_d = 1'b1;
    end else begin
      busy_d         = 16'd0;
      resume_stall_d = 1'b0;
      pc_ld_c        = 1'b1;
      if_id_ld_c     = 1'b1;
      id_exe_ld_c    = 1'b1;
      exe_mem_ld_c   = 1'b1;
      mem_wb_ld_c    = 1'b1;
      if (branch_taken) begin
        if_id_flush_c  = 1'b1;
        id_exe_flush_c = 1'b1;
        state_d        = RUN;
        bub_d          = 3'd0;
      end else if (stalling) begin
        pc_ld_c        = 1'b0;
        if_id_ld_c     = 1'b0;
        id_exe_flush_c = 1'b1;
        if (in_stall) begin
          state_d = STALL;
          bub_d   = (bub_q != 3'd0) ? bub_q - 3'd1 : 3'd0;
        end else begin
          bub_d   = BUB_INIT;
          state_d = (BUB_INIT != 3'd0) ? STALL : RUN;
        end
      end else begin
        state_d = RUN;
        bub_d   = 3'd0;
      end
    end

    cnt_d = (!pc_ld_c && (cnt_q != {CNT_W{1'b1}})) ? cnt_q + {{(CNT_W-1){1'b0}}, 1'b1} : cnt_q;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q        <= RUN;
      bub_q          <= 3'd0;
      busy_q         <= 16'd0;
      err_q          <= 1'b0;
      resume_stall_q <= 1'b0;
      cnt_q          <= '0;
    end else begin
      state_q        <= state_d;
      bub_q          <= bub_d;
      busy_q         <= busy_d;
      err_q          <= err_d;
      resume_stall_q <= resume_stall_d;
      cnt_q          <= cnt_d;
    end
  end

  // Enables are forced low for as long as reset is asserted, independent of the clock.
  assign pc_ld        = pc_ld_c        & ~RST;
  assign if_id_ld     = if_id_ld_c     & ~RST;
  assign if_id_flush  = if_id_flush_c  & ~RST;
  assign id_exe_ld    = id_exe_ld_c    & ~RST;
  assign id_exe_flush = id_exe_flush_c & ~RST;
  assign exe_mem_ld   = exe_mem_ld_c   & ~RST;
  assign mem_wb_ld    = mem_wb_ld_c    & ~RST;
  assign mem_err      = err_q;
  assign stall_cnt    = cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios then random traffic against a cycle-level reference model.
module tb_pipe_hazard_ctrl;

  localparam int LB = 3;
  localparam int TO = 255;

  logic        CLK = 1'b0;
  logic        RST;
  logic [3:0]  src1, src2, exe_dest, mem_dest;
  logic        two_src, id_valid, exe_wb_en, exe_mem_r_en, mem_wb_en, branch_taken, mem_busy;
  logic        pc_ld, if_id_ld, if_id_flush, id_exe_ld, id_exe_flush, exe_mem_ld, mem_wb_ld, mem_err;
  logic [31:0] stall_cnt;
  logic [6:0]  outs;

  int checks = 0;
  int errors = 0;

  // Reference model state: forced bubbles still owed, whether the last issue cycle stalled,
  // length of the current busy run, sticky error, and the count of cycles with the PC held.
  int pend;
  bit in_stall;
  int busy_run;
  bit err;
  int stalls;

  pipe_hazard_ctrl #(.LOAD_BUBBLES(LB), .MEM_TIMEOUT(TO), .CNT_W(32)) dut (
    .CLK(CLK), .RST(RST),
    .src1(src1), .src2(src2), .two_src(two_src), .id_valid(id_valid),
    .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
    .mem_dest(mem_dest), .mem_wb_en(mem_wb_en),
    .branch_taken(branch_taken), .mem_busy(mem_busy),
    .pc_ld(pc_ld), .if_id_ld(if_id_ld), .if_id_flush(if_id_flush),
    .id_exe_ld(id_exe_ld), .id_exe_flush(id_exe_flush),
    .exe_mem_ld(exe_mem_ld), .mem_wb_ld(mem_wb_ld),
    .mem_err(mem_err), .stall_cnt(stall_cnt)
  );

  assign outs = {pc_ld, if_id_ld, if_id_flush, id_exe_ld, id_exe_flush, exe_mem_ld, mem_wb_ld};

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit id_reads(input logic [3:0] r);
    return id_valid && ((src1 == r) || (two_src && (src2 == r)));
  endfunction

  function automatic bit model_hazard();
`ifdef FORWARDING_EN
    return exe_wb_en && exe_mem_r_en && id_reads(exe_dest);
`else
    return (exe_wb_en && id_reads(exe_dest)) || (mem_wb_en && id_reads(mem_dest));
`endif
  endfunction

  task automatic model_reset();
    pend = 0; in_stall = 0; busy_run = 0; err = 0; stalls = 0;
  endtask

  task automatic idle();
    src1 = 4'd0; src2 = 4'd0; two_src = 1'b0; id_valid = 1'b0;
    exe_dest = 4'd0; exe_wb_en = 1'b0; exe_mem_r_en = 1'b0;
    mem_dest = 4'd0; mem_wb_en = 1'b0; branch_taken = 1'b0; mem_busy = 1'b0;
  endtask

  // One clock: check at the falling edge, advance the model, return just after the rising edge.
  task automatic cycle();
    logic [6:0] e;
    bit h, stall_now;
    @(negedge CLK);
    h = model_hazard();
    stall_now = (pend > 0) || h;
    if (RST || mem_busy)    e = 7'b0000000;
    else if (branch_taken)  e = 7'b1111111;
    else if (stall_now)     e = 7'b0001111;
    else                    e = 7'b1101011;
    chk("enables", 32'(outs), 32'(e));
    chk("mem_err", 32'(mem_err), 32'(err));
    chk("stall_cnt", stall_cnt, 32'(stalls));
    if (!RST) begin
      if (mem_busy) begin
        busy_run++;
        if (busy_run >= TO) err = 1;
        stalls++;
      end else begin
        busy_run = 0;
        if (branch_taken) begin
          pend = 0; in_stall = 0;
        end else if (stall_now) begin
          stalls++;
          pend = in_stall ? ((pend > 0) ? pend - 1 : 0) : LB - 1;
          in_stall = 1;
        end else begin
          in_stall = 0;
        end
      end
    end
    @(posedge CLK);
    #1;
  endtask

  initial begin
    idle();
    model_reset();
    RST = 1'b1;
    #12;
    cycle();
    cycle();
    chk("reset_stall_cnt", stall_cnt, 32'd0);
    RST = 1'b0;
    cycle();

    // ALU producer in EXE feeding src1
    id_valid = 1'b1; src1 = 4'd3; exe_dest = 4'd3; exe_wb_en = 1'b1;
    cycle();
    idle();
    repeat (4) cycle();

    // load-use: producer in EXE, then in MEM on the following cycle
    id_valid = 1'b1; src1 = 4'd5; src2 = 4'd0; two_src = 1'b1;
    exe_dest = 4'd0; exe_wb_en = 1'b1; exe_mem_r_en = 1'b1;
    cycle();
    exe_wb_en = 1'b0; exe_mem_r_en = 1'b0; mem_dest = 4'd0; mem_wb_en = 1'b1;
    cycle();
    idle();
    repeat (4) cycle();

    // branch together with a hazard: flush wins
    id_valid = 1'b1; src1 = 4'd7; exe_dest = 4'd7; exe_wb_en = 1'b1; exe_mem_r_en = 1'b1;
    branch_taken = 1'b1;
    cycle();
    idle();
    repeat (2) cycle();

    // memory wait arriving in the middle of a stall
    id_valid = 1'b1; src1 = 4'd2; exe_dest = 4'd2; exe_wb_en = 1'b1; exe_mem_r_en = 1'b1;
    cycle();
    idle();
    mem_busy = 1'b1;
    repeat (3) cycle();
    mem_busy = 1'b0;
    repeat (4) cycle();

    // long memory wait crossing the timeout, then error must stay sticky
    mem_busy = 1'b1;
    repeat (256) cycle();
    mem_busy = 1'b0;
    repeat (3) cycle();

    // asynchronous reset between edges while frozen
    mem_busy = 1'b1;
    repeat (2) cycle();
    #2;
    RST = 1'b1;
    #1;
    chk("async_rst_enables", 32'(outs), 32'd0);
    chk("async_rst_mem_err", 32'(mem_err), 32'd0);
    chk("async_rst_stall_cnt", stall_cnt, 32'd0);
    model_reset();
    #10;
    mem_busy = 1'b0;
    RST = 1'b0;
    @(posedge CLK);
    #1;
    repeat (3) cycle();

    // random traffic over a small register range to provoke frequent matches
    for (int i = 0; i < 1500; i++) begin
      id_valid     = ($urandom_range(3, 0) != 0);
      src1         = 4'($urandom_range(3, 0));
      src2         = 4'($urandom_range(3, 0));
      two_src      = 1'($urandom_range(1, 0));
      exe_dest     = 4'($urandom_range(3, 0));
      exe_wb_en    = 1'($urandom_range(1, 0));
      exe_mem_r_en = 1'($urandom_range(1, 0));
      mem_dest     = 4'($urandom_range(3, 0));
      mem_wb_en    = 1'($urandom_range(1, 0));
      branch_taken = ($urandom_range(7, 0) == 0);
      mem_busy     = ($urandom_range(11, 0) == 0);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
